// File: rtl/data_mem_responder.sv
// Data-port memory responder: word RAM, one access at a time, fixed or
// jittered latency. Optional stall jitter: define DMEM_STALL_INJECT_EN.
// Ports:
//   clk, rst (async active-low)
//   mem_req_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i: request
//   mem_data_o, mem_valid_o, mem_ready_o, mem_err_o: registered response
module data_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_data_o,
  output logic        mem_valid_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int CW = 5;

  logic [31:0]   ram [2**ADDR_WIDTH];
  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [3:0]    sel_q;

  logic [1:0]    extra;
  logic [CW-1:0] busy_len;
  logic          fire;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_data;
  logic [3:0]    acc_sel;
  logic [ADDR_WIDTH-1:0] idx;
  logic          oor;
  logic          unused_lsb;

`ifdef DMEM_STALL_INJECT_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, free-running out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra = lfsr[1:0];
`else
  assign extra = 2'b00;
`endif

  // Cycles spent in BUSY; zero means respond on the accept edge
  assign busy_len = CW'(LATENCY - 1) + CW'(extra);

  // In IDLE the access (if any) uses the live request; later the latched copy
  assign acc_we   = (state == IDLE) ? mem_we_i   : we_q;
  assign acc_addr = (state == IDLE) ? mem_addr_i : addr_q;
  assign acc_data = (state == IDLE) ? mem_data_i : data_q;
  assign acc_sel  = (state == IDLE) ? mem_sel_i  : sel_q;

  assign idx = acc_addr[ADDR_WIDTH+1:2];
  assign oor = |acc_addr[31:ADDR_WIDTH+2];
  assign unused_lsb = ^acc_addr[1:0];

  // Edge that enters RESP: the access itself happens here
  assign fire = (state == IDLE && mem_req_i && busy_len == '0)
             || (state == BUSY && cnt == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      mem_data_o  <= '0;
      mem_valid_o <= 1'b0;
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
    end else begin
      mem_valid_o <= 1'b0;
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_req_i) begin
            we_q   <= mem_we_i;
            addr_q <= mem_addr_i;
            data_q <= mem_data_i;
            sel_q  <= mem_sel_i;
            cnt    <= busy_len;
            state  <= (busy_len == '0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        mem_ready_o <= 1'b1;
        mem_err_o   <= oor;
        if (!acc_we) begin
          mem_valid_o <= 1'b1;
          mem_data_o  <= oor ? 32'h0 : ram[idx];
        end
      end
    end
  end

  // RAM is not reset; the rst term keeps a reset edge from writing
  always_ff @(posedge clk) begin
    if (rst && fire && acc_we && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) begin
          ram[idx][8*b +: 8] <= acc_data[8*b +: 8];
        end
      end
    end
  end

endmodule
